// File: rtl/instruction_loader.sv
// instruction_loader
//   Writer side of instruction memory. Receives a framed byte stream over a
//   valid/ready link, assembles big-endian 32-bit words and writes them to
//   consecutive word addresses starting at BASE_ADDR. The cores are held in
//   stall until the frame has been loaded successfully.
//
//   Frame: LEN_HI, LEN_LO (word count N), N x 4 data bytes (MSB first),
//          then one XOR checksum byte over the data bytes when
//          LOADER_CHECKSUM_EN is defined.
//
//   Configuration macro: LOADER_CHECKSUM_EN (checksum byte and CHECK state).
//
// Ports
//   Clk         clock, rising edge
//   Reset       synchronous, active-high
//   in_data     stream byte
//   in_valid    in_data valid
//   in_ready    loader accepts a byte this cycle
//   im_we       one-cycle write strobe per assembled word
//   im_addr     word address of the write
//   im_wdata    word to write
//   core_hold   stall for all cores while high
//   load_done   sticky, frame loaded successfully
//   load_error  sticky, frame rejected
module instruction_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_FINAL  = S_CHECK;
`else
  localparam logic [2:0] S_FINAL  = 3'd4;
`endif
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam logic [31:0] MAX_WORDS = (32'd1 << ADDR_WIDTH) - 32'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;      // LEN_HI staging, then words left
  logic [1:0]            bcnt_q, bcnt_d;    // byte position within a word
  logic [23:0]           word_q, word_d;    // first three bytes of a word
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_full;

  assign in_ready   = (state_q != S_DONE) && (state_q != S_ERROR);
  assign accept     = in_valid && in_ready;
  assign len_full   = {cnt_q[15:8], in_data};

  assign im_we      = we_q;
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign core_hold  = (state_q != S_DONE);
  assign load_done  = (state_q == S_DONE);
  assign load_error = (state_q == S_ERROR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    // Advance past a word once its write strobe has gone out. The count
    // check guarantees the last write lands at or below the top address,
    // so holding there keeps the index from wrapping.
    if (we_q && (addr_q != '1)) addr_d = addr_q + ADDR_ONE;

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          cnt_d   = {in_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          cnt_d = len_full;
          if ({16'd0, len_full} > MAX_WORDS) state_d = S_ERROR;
          else if (len_full == 16'd0)        state_d = S_FINAL;
          else                               state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {word_q, in_data};
            cnt_d   = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = S_FINAL;
          end else begin
            word_d = {word_q[15:0], in_data};
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: ;  // DONE / ERROR hold until Reset
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_LEN_HI;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      addr_q  <= BASE;
      we_q    <= 1'b0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed frames plus randomized frames, all
// checked every cycle against a frame-level model built from byte positions.
module tb_instruction_loader;

  localparam int AW   = 4;
  localparam int BASE = 2;
  localparam int CAP  = (1 << AW) - BASE;  // 14 words
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic          Clk = 1'b0;
  logic          Reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_error;

  int total = 0;
  int bad   = 0;

  instruction_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .core_hold(core_hold), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xr(input bq_t d);
    logic [7:0] x = 8'h00;
    foreach (d[i]) x ^= d[i];
    return x;
  endfunction

  // ---------------- frame-level model ----------------
  // Status: 0 loading, 1 done, 2 error. Everything is derived from how many
  // bytes of the frame have been accepted since the last reset.
  logic [7:0]  fb[$];
  int          m_status = 0;
  int          m_count  = 0;
  bit          m_init   = 0;
  bit          m_we     = 0;
  int          m_addr   = 0;
  logic [31:0] m_data   = '0;

  always @(posedge Clk) begin
    int n;
    logic [7:0] x;
    m_we = 0;
    if (Reset) begin
      fb.delete();
      m_status = 0;
      m_count  = 0;
      m_init   = 1;
    end else if (m_init && in_valid && m_status == 0) begin
      fb.push_back(in_data);
      n = fb.size();
      if (n == 2) begin
        m_count = int'(fb[0]) * 256 + int'(fb[1]);
        if (m_count > CAP) m_status = 2;
        else if (m_count == 0 && !CHK) m_status = 1;
      end else if (n > 2 && n <= 2 + 4 * m_count) begin
        if ((n - 2) % 4 == 0) begin
          m_we   = 1;
          m_addr = BASE + (n - 2) / 4 - 1;
          m_data = {fb[n-4], fb[n-3], fb[n-2], fb[n-1]};
        end
        if (n == 2 + 4 * m_count && !CHK) m_status = 1;
      end else if (n == 3 + 4 * m_count) begin
        x = 8'h00;
        for (int i = 2; i < n - 1; i++) x ^= fb[i];
        m_status = (fb[n-1] == x) ? 1 : 2;
      end
    end
  end

  // DUT writes as observed, for the directed literal checks.
  int          wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge Clk) begin
    if (m_init) begin
      chk("in_ready",   32'(in_ready),   32'(m_status == 0));
      chk("core_hold",  32'(core_hold),  32'(m_status != 1));
      chk("load_done",  32'(load_done),  32'(m_status == 1));
      chk("load_error", 32'(load_error), 32'(m_status == 2));
      chk("im_we",      32'(im_we),      32'(m_we));
      if (m_we) begin
        chk("im_addr",  32'(im_addr), 32'(m_addr));
        chk("im_wdata", im_wdata,     m_data);
      end
    end
    if (im_we) begin
      wr_addr.push_back(int'(im_addr));
      wr_data.push_back(im_wdata);
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; in_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  // mode 0: back-to-back, 1: idle cycle before every byte, 2: random gaps
  task automatic send_byte(input logic [7:0] b, input int mode);
    int t = 0;
    @(negedge Clk);
    if (mode == 1) begin
      in_valid = 1'b0;
      @(negedge Clk);
    end else if (mode == 2) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge Clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL handshake_timeout act=in_ready_low exp=in_ready_high t=%0t", $time);
    end
  endtask

  task automatic send_list(input bq_t l, input int mode);
    foreach (l[i]) send_byte(l[i], mode);
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  function automatic bq_t mk_frame(input int cnt, input bq_t data, input bit good);
    bq_t f;
    f.push_back(8'(cnt >> 8));
    f.push_back(8'(cnt));
    if (cnt <= CAP) begin
      foreach (data[i]) f.push_back(data[i]);
      if (CHK) f.push_back(good ? xr(data) : (xr(data) ^ 8'h5A));
    end
    return f;
  endfunction

  initial begin
    bq_t d, f;
    Reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;

    // 1: reset state, single word
    do_reset();
    chk("rst_addr",  32'(im_addr), 32'(BASE));
    chk("rst_wdata", im_wdata, 32'h0);
    chk("rst_hold",  32'(core_hold), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    chk("xor_pin", 32'(xr(d)), 32'h22);
    send_list(mk_frame(1, d, 1'b1), 0);
    repeat (3) @(negedge Clk);
    chk("t1_nwr",  32'(wr_addr.size()), 32'd1);
    chk("t1_addr", 32'(wr_addr[0]), 32'(BASE));
    chk("t1_data", wr_data[0], 32'hDEADBEEF);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_hold", 32'(core_hold), 32'd0);

    // 2: two words with in_valid toggling
    do_reset();
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    chk("xor_pin2", 32'(xr(d)), 32'h88);
    send_list(mk_frame(2, d, 1'b1), 1);
    repeat (3) @(negedge Clk);
    chk("t2_nwr",   32'(wr_addr.size()), 32'd2);
    chk("t2_data0", wr_data[0], 32'h11223344);
    chk("t2_addr1", 32'(wr_addr[1]), 32'(BASE + 1));
    chk("t2_data1", wr_data[1], 32'h55667788);
    chk("t2_done",  32'(load_done), 32'd1);

    // 3: wrong checksum (when present), then 20 ignored cycles of in_valid
    do_reset();
    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_list(mk_frame(1, d, 1'b0), 0);
    repeat (20) begin
      @(negedge Clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    @(negedge Clk);
    in_valid = 1'b0;
    chk("t3_nwr",   32'(wr_addr.size()), 32'd1);
    chk("t3_data",  wr_data[0], 32'hDEADBEEF);
    chk("t3_err",   32'(load_error), CHK ? 32'd1 : 32'd0);
    chk("t3_hold",  32'(core_hold),  CHK ? 32'd1 : 32'd0);
    chk("t3_ready", 32'(in_ready), 32'd0);

    // 4: oversize counts rejected, exact-fit count accepted
    do_reset();
    send_list(mk_frame(17, d, 1'b1), 0);
    repeat (3) @(negedge Clk);
    chk("t4_err17", 32'(load_error), 32'd1);
    chk("t4_nwr17", 32'(wr_addr.size()), 32'd0);
    do_reset();
    send_list(mk_frame(CAP + 1, d, 1'b1), 0);
    repeat (3) @(negedge Clk);
    chk("t4_err15", 32'(load_error), 32'd1);
    do_reset();
    d.delete();
    for (int i = 0; i < 4 * CAP; i++) d.push_back(8'($urandom));
    send_list(mk_frame(CAP, d, 1'b1), 2);
    repeat (3) @(negedge Clk);
    chk("t4_nwr14",  32'(wr_addr.size()), 32'(CAP));
    chk("t4_last",   32'(wr_addr[CAP-1]), 32'd15);
    chk("t4_done14", 32'(load_done), 32'd1);

    // 5: empty frame
    do_reset();
    d.delete();
    send_list(mk_frame(0, d, 1'b1), 0);
    repeat (2) @(negedge Clk);
    chk("t5_done", 32'(load_done), 32'd1);
    chk("t5_nwr",  32'(wr_addr.size()), 32'd0);

    // 6: reset in the middle of a word, then a fresh frame
    do_reset();
    f = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_list(f, 0);
    do_reset();
    chk("t6_nwr0", 32'(wr_addr.size()), 32'd0);
    chk("t6_rdy",  32'(in_ready), 32'd1);
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_list(mk_frame(1, d, 1'b1), 0);
    repeat (3) @(negedge Clk);
    chk("t6_nwr",  32'(wr_addr.size()), 32'd1);
    chk("t6_addr", 32'(wr_addr[0]), 32'(BASE));
    chk("t6_data", wr_data[0], 32'h01020304);
    chk("t6_done", 32'(load_done), 32'd1);

    // 7: randomized frames, checked by the per-cycle compare
    for (int k = 0; k < 40; k++) begin
      int cnt;
      do_reset();
      cnt = $urandom_range(0, CAP + 2);
      d.delete();
      if (cnt <= CAP)
        for (int i = 0; i < 4 * cnt; i++) d.push_back(8'($urandom));
      f = mk_frame(cnt, d, $urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0)
        while (f.size() > 1 && $urandom_range(0, 3) != 0) void'(f.pop_back());
      send_list(f, $urandom_range(0, 2));
      repeat (3) @(negedge Clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
